pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
Parametrised successor to the fabric-side PLL lock handling. It synchronises the raw PLL lock, requires the lock to be stable for a set time, and then releases NUM_CH active-low domain resets one after another. It also reports lock loss (sticky) and counts relock events. It sits next to the CC_PLL/CC_BUFG instance and runs on the buffered PLL output clock.

Parameters:
SYNC_STAGES, 2, flops in pll_lock_in synchroniser (>=2)
LOCK_FILTER, 16, consecutive qualified-lock samples required before locked asserts (>=1)
NUM_CH, 4, number of sequenced reset outputs (>=1)
STAGE_DELAY, 8, cycles between successive channel releases and from locked to channel 0 (>=1)
CNT_W, 8, width of relock_count

Ports:
clock_in  input  1  buffered PLL output clock; the only clock
rst_n_in  input  1  asynchronous, active-low reset
pll_lock_in  input  1  raw PLL lock (USR_PLL_LOCKED), asynchronous to clock_in
sw_rst_in  input  1  synchronous soft reset, active-high; forces the unlocked path
clr_lost_in  input  1  synchronous one-cycle pulse; clears lock_lost
locked  output  1  qualified lock, registered
rst_n_out  output  NUM_CH  per-domain resets, active-low; bit k is released k-th
all_released  output  1  high when every rst_n_out bit is 1
lock_lost  output  1  sticky; set when the lock drops while locked=1
relock_count  output  CNT_W  number of locked rising edges after the first, saturating

Behaviour:
- Async reset (rst_n_in=0): locked=0, rst_n_out=0, all_released=0, lock_lost=0, relock_count=0, sync chain=0, state=WAIT_LOCK, all counters=0.
- lock_s is the output of the SYNC_STAGES synchroniser. q = lock_s & ~sw_rst_in.
- States: WAIT_LOCK, QUALIFY, RELEASE, RUN.
- WAIT_LOCK:
  - Filter counter is held at 0.
  - Edge sampling q=1 -> QUALIFY with count=1. If LOCK_FILTER=1, go directly to RELEASE with locked=1.
- QUALIFY:
  - q=0 -> WAIT_LOCK, count=0.
  - Otherwise count++.
  - On the LOCK_FILTER-th consecutive q=1 sample: locked<=1, go to RELEASE, delay counter=0, channel index=0.
- RELEASE:
  - Delay counter increments each cycle.
  - rst_n_out[k] goes 1 exactly STAGE_DELAY*(k+1) cycles after locked rises.
  - After bit NUM_CH-1 is released: all_released<=1 on the same edge, go to RUN.
  - Released bits stay 1.
- Any state with q sampled 0 while locked=1 or in RELEASE/RUN:
  - On that same edge: locked, rst_n_out (all bits), all_released <= 0.
  - Counters clear; go to WAIT_LOCK.
  - No partial release survives.
- lock_lost:
  - Set on the edge where lock_s is sampled 0 while locked=1.
  - sw_rst_in alone does not set it.
  - Cleared by clr_lost_in. If set and clear happen on the same edge, set wins.
- relock_count: increments on each locked 0->1 transition except the first since rst_n_in; saturates at 2^CNT_W-1.
- Latency from a clean pll_lock_in rise (held stable before edge 1):
  - locked high after edge SYNC_STAGES+LOCK_FILTER.
  - Lock drop: outputs low after edge p+SYNC_STAGES, where p is the first edge sampling pll_lock_in=0.
- sw_rst_in asserted mid-sequence behaves like a lock drop, except lock_lost is untouched. Its release restarts qualification from WAIT_LOCK.
- Reset mid-operation: asynchronous return to reset values; no glitch on rst_n_out (registered outputs only).
- All outputs come straight from flops; no combinational paths from inputs to outputs.

Decomposition:
- Package pll_seq_pkg: state enum (WAIT_LOCK, QUALIFY, RELEASE, RUN) and default parameter constants.
- Sub-module sync_bit: SYNC_STAGES-deep synchroniser with async active-low reset to 0, used for pll_lock_in.
- Counters and FSM stay in pll_lock_sequencer.

Test Plan:
- Defaults, pll_lock_in tied 1 from edge 1 -> locked=1 after edge 18; rst_n_out[0..3] rise after edges 26/34/42/50; all_released after edge 50; relock_count=0.
- pll_lock_in glitches low for 1 cycle at edge 10 (during QUALIFY) -> no locked assertion; qualification restarts; locked rises 16 samples after lock_s returns high; lock_lost stays 0.
- Locked and in RUN, pll_lock_in drops at edge p -> locked/rst_n_out/all_released=0 after edge p+2; lock_lost=1. Relock -> relock_count=1; full sequence repeats with the same spacing.
- sw_rst_in pulsed 3 cycles while in RUN -> all outputs drop on the next edge; lock_lost stays 0. Sequence restarts; locked returns 16 cycles after sw_rst_in deasserts.
- clr_lost_in on the same edge as a new lock drop -> lock_lost remains 1. clr_lost_in alone -> lock_lost=0 after the next edge.
- CNT_W=2, force 5 relocks -> relock_count saturates at 3. Also run with LOCK_FILTER=1, NUM_CH=1, STAGE_DELAY=1: locked after edge 3, rst_n_out[0] and all_released after edge 4.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and default parameter values for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_FILTER = 16;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_STAGE_DELAY = 8;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    QUALIFY,
    RELEASE,
    RUN
  } seq_state_e;

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, reset to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies the synchronised PLL lock, then releases NUM_CH domain resets in
// sequence; tracks sticky lock loss and a saturating relock counter.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clock_in,
  input  logic              rst_n_in,
  input  logic              pll_lock_in,
  input  logic              sw_rst_in,
  input  logic              clr_lost_in,
  output logic              locked,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              all_released,
  output logic              lock_lost,
  output logic [CNT_W-1:0]  relock_count
);

  localparam int FLT_W = $clog2(LOCK_FILTER + 1);
  localparam int DLY_W = $clog2(STAGE_DELAY + 1);
  localparam int CH_W  = $clog2(NUM_CH + 1);

  logic lock_s;
  logic q;

  seq_state_e        state_q,   state_d;
  logic [FLT_W-1:0]  flt_q,     flt_d;
  logic [DLY_W-1:0]  dly_q,     dly_d;
  logic [CH_W-1:0]   ch_q,      ch_d;
  logic              locked_q,  locked_d;
  logic [NUM_CH-1:0] rst_q,     rst_d;
  logic              all_rel_q, all_rel_d;
  logic              lost_q,    lost_d;
  logic              seen_q,    seen_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (rst_n_in),
    .d     (pll_lock_in),
    .q     (lock_s)
  );

  assign q = lock_s & ~sw_rst_in;

  // NOTE: every next-state signal takes its hold value first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    flt_d     = flt_q;
    dly_d     = dly_q;
    ch_d      = ch_q;
    locked_d  = locked_q;
    rst_d     = rst_q;
    all_rel_d = all_rel_q;
    lost_d    = lost_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;

    case (state_q)
      WAIT_LOCK: begin
        flt_d = '0;
        if (q) begin
          if (LOCK_FILTER == 1) begin
            locked_d = 1'b1;
            state_d  = RELEASE;
            dly_d    = '0;
            ch_d     = '0;
          end else begin
            flt_d   = FLT_W'(1);
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (!q) begin
          flt_d   = '0;
          state_d = WAIT_LOCK;
        end else if (flt_q == FLT_W'(LOCK_FILTER - 1)) begin
          locked_d = 1'b1;
          state_d  = RELEASE;
          flt_d    = '0;
          dly_d    = '0;
          ch_d     = '0;
        end else begin
          flt_d = flt_q + FLT_W'(1);
        end
      end
      RELEASE: begin
        if (dly_q == DLY_W'(STAGE_DELAY - 1)) begin
          dly_d = '0;
          rst_d = rst_q | (NUM_CH'(1) << ch_q);
          ch_d  = ch_q + CH_W'(1);
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            all_rel_d = 1'b1;
            state_d   = RUN;
          end
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      RUN: ;
      default: state_d = WAIT_LOCK;
    endcase

    // Losing the qualified lock overrides any partial release in progress.
    if (!q && (locked_q || state_q == RELEASE || state_q == RUN)) begin
      state_d   = WAIT_LOCK;
      locked_d  = 1'b0;
      rst_d     = '0;
      all_rel_d = 1'b0;
      flt_d     = '0;
      dly_d     = '0;
      ch_d      = '0;
    end

    // Only a real lock drop is sticky; a soft reset leaves lock_lost alone.
    if (!lock_s && locked_q) lost_d = 1'b1;
    else if (clr_lost_in)    lost_d = 1'b0;

    if (locked_d && !locked_q) begin
      if (!seen_q)          seen_d = 1'b1;
      else if (cnt_q != '1) cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= WAIT_LOCK;
      flt_q     <= '0;
      dly_q     <= '0;
      ch_q      <= '0;
      locked_q  <= 1'b0;
      rst_q     <= '0;
      all_rel_q <= 1'b0;
      lost_q    <= 1'b0;
      seen_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      flt_q     <= flt_d;
      dly_q     <= dly_d;
      ch_q      <= ch_d;
      locked_q  <= locked_d;
      rst_q     <= rst_d;
      all_rel_q <= all_rel_d;
      lost_q    <= lost_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
    end
  end

  assign locked       = locked_q;
  assign rst_n_out    = rst_q;
  assign all_released = all_rel_q;
  assign lock_lost    = lost_q;
  assign relock_count = cnt_q;

endmodule
